// File: rtl/xor_seq_pkg.sv
// ---------------------------------------------------------------------------
// xor_seq_pkg
// Shared types and constants for the XOR training sequencer.
//   state_t      : sequencer FSM states
//   class_t      : 2-bit network class value
//   PAT_ROM      : 4-entry {x,y} pattern table, order 00, 10, 01, 11
//   pat_x/pat_y  : operand lookups into PAT_ROM
//   golden_class : reference XOR class for a pattern index
// ---------------------------------------------------------------------------
package xor_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_TRAIN,
        ST_TEST,
        ST_DONE
    } state_t;

    typedef logic [1:0] class_t;

    // Entry i is {x,y}; packed concatenation lists index 3 first.
    localparam logic [3:0][1:0] PAT_ROM = {2'b11, 2'b01, 2'b10, 2'b00};

    function automatic logic pat_x(input logic [1:0] idx);
        return PAT_ROM[idx][1];
    endfunction

    function automatic logic pat_y(input logic [1:0] idx);
        return PAT_ROM[idx][0];
    endfunction

    function automatic class_t golden_class(input logic [1:0] idx);
        return {1'b0, PAT_ROM[idx][1] ^ PAT_ROM[idx][0]};
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/xor_seq_scoreboard.sv
// ---------------------------------------------------------------------------
// xor_seq_scoreboard
// Accumulates the test-pass score for the XOR sequencer.
//   clk_i, rst_i       : clock, async active-high reset
//   clear_i            : zero all results (new run)
//   sample_i           : strobe on the last hold cycle of a test pattern
//   idx_i              : pattern index being sampled
//   predicted_i        : network output class
//   expected_i         : network target class
//   pass_count_o       : number of matching samples (0..4)
//   fail_mask_o        : bit i set if pattern i mismatched
//   expected_err_o     : sticky golden-check flag
// Optional feature: XOR_SEQ_GOLDEN_EN enables checking expected_i against
// the internal XOR golden; otherwise expected_err_o is tied to 0.
// ---------------------------------------------------------------------------
module xor_seq_scoreboard
    import xor_seq_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clear_i,
    input  logic       sample_i,
    input  logic [1:0] idx_i,
    input  class_t     predicted_i,
    input  class_t     expected_i,
    output logic [2:0] pass_count_o,
    output logic [3:0] fail_mask_o,
    output logic       expected_err_o
);

    logic [2:0] pass_q;
    logic [3:0] mask_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pass_q <= '0;
            mask_q <= '0;
        end else if (clear_i) begin
            pass_q <= '0;
            mask_q <= '0;
        end else if (sample_i) begin
            if (predicted_i == expected_i)
                pass_q <= pass_q + 3'd1;
            else
                mask_q[idx_i] <= 1'b1;
        end
    end

    assign pass_count_o = pass_q;
    assign fail_mask_o  = mask_q;

`ifdef XOR_SEQ_GOLDEN_EN
    logic err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            err_q <= 1'b0;
        else if (clear_i)
            err_q <= 1'b0;
        else if (sample_i && (expected_i != golden_class(idx_i)))
            err_q <= 1'b1;
    end

    assign expected_err_o = err_q;
`else
    assign expected_err_o = 1'b0;
`endif

endmodule

// File: rtl/xor_training_sequencer.sv
// ---------------------------------------------------------------------------
// xor_training_sequencer
// Drives a 2-in/1-out XOR network through init, EPOCHS training passes and
// one test pass, then scores the test pass.
//   clk, reset        : clock, async active-high reset
//   start             : begin a run (honoured in IDLE/DONE only)
//   predicted         : network output class
//   expected          : network target class
//   reset_value       : network weight-initialise request
//   TestFlag          : network inference mode
//   x_input, y_input  : network operands
//   busy              : high in INIT/TRAIN/TEST
//   done              : high in DONE
//   pass_count        : matching test patterns (0..4)
//   fail_mask         : bit i set if test pattern i mismatched
//   expected_err      : golden-check flag
// Optional feature: XOR_SEQ_GOLDEN_EN (golden check of `expected`).
// ---------------------------------------------------------------------------
module xor_training_sequencer
    import xor_seq_pkg::*;
#(
    parameter int INIT_CYCLES      = 4,
    parameter int HOLD_CYCLES      = 10,
    parameter int TEST_HOLD_CYCLES = 5,
    parameter int EPOCHS           = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] predicted,
    input  logic [1:0] expected,
    output logic       reset_value,
    output logic       TestFlag,
    output logic       x_input,
    output logic       y_input,
    output logic       busy,
    output logic       done,
    output logic [2:0] pass_count,
    output logic [3:0] fail_mask,
    output logic       expected_err
);

    localparam int HOLD_MAX = max3(HOLD_CYCLES, TEST_HOLD_CYCLES, INIT_CYCLES);
    localparam int CW       = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam int EW       = $clog2(EPOCHS) + 1;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    pat_q;
    logic [EW-1:0] epoch_q;
    logic          rv_q, tf_q, x_q, y_q, busy_q, done_q;

    logic start_go;
    logic init_last, train_last, test_last;
    logic sample;
    logic [1:0] pat_nxt;

    assign start_go   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign init_last  = (cnt_q == CW'(INIT_CYCLES - 1));
    assign train_last = (cnt_q == CW'(HOLD_CYCLES - 1));
    assign test_last  = (cnt_q == CW'(TEST_HOLD_CYCLES - 1));
    assign sample     = (state_q == ST_TEST) && test_last;
    // 2-bit index wraps 3 -> 0 naturally, giving pattern 0 at epoch rollover.
    assign pat_nxt    = pat_q + 2'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pat_q   <= '0;
            epoch_q <= '0;
            rv_q    <= 1'b0;
            tf_q    <= 1'b0;
            x_q     <= 1'b0;
            y_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q <= ST_INIT;
                        cnt_q   <= '0;
                        pat_q   <= '0;
                        epoch_q <= '0;
                        rv_q    <= 1'b1;
                        tf_q    <= 1'b0;
                        x_q     <= 1'b0;
                        y_q     <= 1'b0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                ST_INIT: begin
                    if (init_last) begin
                        state_q <= ST_TRAIN;
                        cnt_q   <= '0;
                        pat_q   <= '0;
                        rv_q    <= 1'b0;
                        x_q     <= pat_x(2'd0);
                        y_q     <= pat_y(2'd0);
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_TRAIN: begin
                    if (train_last) begin
                        cnt_q <= '0;
                        pat_q <= pat_nxt;
                        x_q   <= pat_x(pat_nxt);
                        y_q   <= pat_y(pat_nxt);
                        if (pat_q == 2'd3) begin
                            if (epoch_q == EW'(EPOCHS - 1)) begin
                                state_q <= ST_TEST;
                                epoch_q <= '0;
                                tf_q    <= 1'b1;
                            end else begin
                                epoch_q <= epoch_q + EW'(1);
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_TEST: begin
                    if (test_last) begin
                        cnt_q <= '0;
                        if (pat_q == 2'd3) begin
                            state_q <= ST_DONE;
                            pat_q   <= '0;
                            x_q     <= 1'b0;
                            y_q     <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            pat_q <= pat_nxt;
                            x_q   <= pat_x(pat_nxt);
                            y_q   <= pat_y(pat_nxt);
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign reset_value = rv_q;
    assign TestFlag    = tf_q;
    assign x_input     = x_q;
    assign y_input     = y_q;
    assign busy        = busy_q;
    assign done        = done_q;

    // Clearing on the accepted start edge makes the score read zero for the
    // whole of INIT, including its first cycle.
    xor_seq_scoreboard u_score (
        .clk_i          (clk),
        .rst_i          (reset),
        .clear_i        (start_go),
        .sample_i       (sample),
        .idx_i          (pat_q),
        .predicted_i    (predicted),
        .expected_i     (expected),
        .pass_count_o   (pass_count),
        .fail_mask_o    (fail_mask),
        .expected_err_o (expected_err)
    );

endmodule

// File: tb/tb_xor_training_sequencer.sv
module tb_xor_training_sequencer;

    localparam int I  = 4;
    localparam int H  = 10;
    localparam int TH = 5;
    localparam int E  = 5;
    localparam int T0 = I + E * 4 * H + 1;   // first TEST cycle (205)
    localparam int D  = T0 + 4 * TH;         // first DONE cycle (225)

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] predicted;
    logic [1:0] expected;
    logic       reset_value, TestFlag, x_input, y_input, busy, done;
    logic [2:0] pass_count;
    logic [3:0] fail_mask;
    logic       expected_err;

    int checks = 0;
    int errors = 0;

    int         exp_pass;
    logic [3:0] exp_mask;
    logic       exp_err;

    xor_training_sequencer #(
        .INIT_CYCLES      (I),
        .HOLD_CYCLES      (H),
        .TEST_HOLD_CYCLES (TH),
        .EPOCHS           (E)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .predicted    (predicted),
        .expected     (expected),
        .reset_value  (reset_value),
        .TestFlag     (TestFlag),
        .x_input      (x_input),
        .y_input      (y_input),
        .busy         (busy),
        .done         (done),
        .pass_count   (pass_count),
        .fail_mask    (fail_mask),
        .expected_err (expected_err)
    );

    always #5 clk = ~clk;

    // Reference: outputs {reset_value,TestFlag,x,y,busy,done} for run cycle c.
    function automatic logic [5:0] model_ctl(input int c);
        bit [3:0] xs = 4'b1010;   // x per pattern index 0..3 : 0,1,0,1
        bit [3:0] ys = 4'b1100;   // y per pattern index 0..3 : 0,0,1,1
        int p;
        if (c <= I) return 6'b100010;
        if (c < T0) begin
            p = ((c - I - 1) / H) % 4;
            return {1'b0, 1'b0, xs[p], ys[p], 1'b1, 1'b0};
        end
        if (c < D) begin
            p = (c - T0) / TH;
            return {1'b0, 1'b1, xs[p], ys[p], 1'b1, 1'b0};
        end
        return 6'b010001;
    endfunction

    function automatic logic [1:0] golden(input int p);
        bit [3:0] xs = 4'b1010;
        bit [3:0] ys = 4'b1100;
        return {1'b0, xs[p] ^ ys[p]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input int c, input string tag);
        chk({tag, "_ctl"}, 32'({reset_value, TestFlag, x_input, y_input, busy, done}),
            32'(model_ctl(c)));
        chk({tag, "_pass"}, 32'(pass_count), 32'(exp_pass));
        chk({tag, "_mask"}, 32'(fail_mask), 32'(exp_mask));
        chk({tag, "_err"}, 32'(expected_err), 32'(exp_err));
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, 32'({reset_value, TestFlag, x_input, y_input, busy, done,
                      pass_count, fail_mask, expected_err}), 32'd0);
    endtask

    // mode 0: predicted == expected == golden, start pulses while busy
    // mode 1: as 0 but predicted = 11 on test pattern 2
    // mode 2: random expected, predicted matches half the time
    // mode 3: expected = 00 on test pattern 1, predicted follows expected
    task automatic run(input int mode, input int abort_at);
        logic [1:0] g;
        bit         smp;
        int         p;
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_pass = 0;
        exp_mask = 4'b0;
        exp_err  = 1'b0;
        for (int c = 1; c <= D; c++) begin
            chk_all(c, "run");
            start = (mode == 0) && (c == 50 || c == 210);
            smp = (c >= T0) && (c < D) && (((c - T0) % TH) == TH - 1);
            predicted = 2'($urandom);
            expected  = 2'($urandom);
            if (smp) begin
                p = (c - T0) / TH;
                g = golden(p);
                case (mode)
                    0: begin expected = g; predicted = g; end
                    1: begin expected = g; predicted = (p == 2) ? 2'b11 : g; end
                    2: begin if ($urandom_range(1, 0) == 1) predicted = expected; end
                    default: begin expected = (p == 1) ? 2'b00 : g; predicted = expected; end
                endcase
                if (predicted == expected) exp_pass++;
                else exp_mask[p] = 1'b1;
`ifdef XOR_SEQ_GOLDEN_EN
                if (expected != g) exp_err = 1'b1;
`endif
            end
            if (c == abort_at) begin
                #2 reset = 1'b1;
                #1 chk_zero("abort_async");
                tick();
                chk_zero("abort_hold");
                reset = 1'b0;
                start = 1'b0;
                tick();
                chk_zero("abort_idle");
                return;
            end
            tick();
        end
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk_all(D, "done_hold");
            tick();
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        predicted = 2'b00;
        expected  = 2'b00;
        tick();
        tick();
        chk_zero("in_reset");
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            predicted = 2'($urandom);
            expected  = 2'($urandom);
            tick();
            chk_zero("idle");
        end

        run(0, 0);
        chk("m0_pass", 32'(pass_count), 32'd4);
        chk("m0_mask", 32'(fail_mask), 32'd0);
        run(1, 0);                       // restarted from DONE
        chk("m1_pass", 32'(pass_count), 32'd3);
        chk("m1_mask", 32'(fail_mask), 32'b0100);
        run(2, 100);                     // aborted mid-TRAIN
        run(2, 0);
        run(3, 0);
`ifdef XOR_SEQ_GOLDEN_EN
        chk("m3_err", 32'(expected_err), 32'd1);
`else
        chk("m3_err", 32'(expected_err), 32'd0);
`endif
        for (int r = 0; r < 3; r++) run(2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
